lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//  CPU-side load/store initiator for the word-organised data memory. Takes one load/store
//  per handshake from the MEM stage, issues a word-aligned memory request with byte enables,
//  waits for mem_ack, then returns extracted/sign-extended load data or an error.
//  Size codes match the data memory: W=000, H=100, HU=101, B=110, BU=111.
// PARAMETERS
//  TIMEOUT   15  cycles of mem_req without mem_ack before aborting with error (1..255)
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-low; all state and outputs cleared while low
//  req_valid  in   1   pipeline request valid
//  req_ready  out  1   lsu can accept request (high only in IDLE)
//  req_we     in   1   1=store, 0=load
//  req_type   in   3   size code (W/H/HU/B/BU)
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data, right-justified
//  resp_valid out  1   one-cycle pulse: access complete
//  resp_data  out  32  load result (0 for stores and errors)
//  resp_err   out  2   00 ok, 01 misaligned, 10 timeout, 11 illegal req_type
//  mem_req    out  1   memory request, held until mem_ack
//  mem_we     out  1   memory write enable (qualified by mem_req)
//  mem_be     out  4   byte enables, bit i = byte lane i (little-endian)
//  mem_addr   out  32  word address {req_addr[31:2],2'b00}
//  mem_wdata  out  32  lane-replicated store data
//  mem_ack    in   1   memory completed the access this cycle
//  mem_rdata  in   32  read word, valid when mem_ack and !mem_we
// BEHAVIOUR
//  Reset (reset=0): state=IDLE; req_ready=1 once released; mem_req, mem_we, resp_valid=0;
//   mem_be, mem_addr, mem_wdata, resp_data=0; resp_err=00; timeout counter=0.
//  FSM: IDLE -> ACCESS -> RESP -> IDLE; IDLE -> RESP directly on misaligned/illegal request.
//  IDLE: accept when req_valid&req_ready; latch we, type, addr[1:0], wdata.
//   Illegal type (001,010,011): -> RESP, err=11, no memory access.
//   Misaligned (W with addr[1:0]!=0, H/HU with addr[0]=1): -> RESP, err=01, no access.
//   Otherwise drive mem_* registered; -> ACCESS (mem_req rises cycle after accept).
//  Byte enables: W 1111; H/HU addr[1]?1100:0011; B/BU 0001<<addr[1:0]. Loads drive same be.
//  mem_wdata: W wdata; H {2{wdata[15:0]}}; B {4{wdata[7:0]}}.
//  ACCESS: mem_req,mem_we,mem_be,mem_addr,mem_wdata held stable until mem_ack sampled high.
//   mem_ack=1: capture mem_rdata, drop mem_req next cycle, -> RESP, err=00.
//   Counter increments each ACCESS cycle without ack; ack on same cycle count hits TIMEOUT
//   wins (ok). Count reaches TIMEOUT without ack: drop mem_req, -> RESP, err=10.
//   mem_ack outside ACCESS ignored.
//  RESP: resp_valid=1 for exactly one cycle; next cycle back to IDLE, req_ready=1.
//   Load data: W rdata; H/HU half = addr[1]?rdata[31:16]:rdata[15:0]; B/BU byte lane addr[1:0].
//   H,B sign-extend; HU,BU zero-extend. Stores/errors: resp_data=0.
//   resp_data, resp_err hold until next resp_valid.
//  Latency (ok, ack in first ACCESS cycle): accept edge N, mem_req high N+1, resp_valid N+2.
//  One outstanding access; req_ready=0 in ACCESS and RESP; no request accepted in RESP cycle.
//  Reset asserted mid-ACCESS: mem_req drops immediately (async), no response issued.
// TESTING
//  SW addr 0x10 wdata 0xDEADBEEF, ack after 2 cycles -> mem_be=1111, mem_addr=0x10, err=00.
//  SB addr 0x13 wdata 0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5; LB same addr with
//   rdata 0xA5000000 -> resp_data=0xFFFFFFA5; LBU -> 0x000000A5.
//  LH addr 0x22, rdata 0x8001_1234 -> be=1100, resp_data=0xFFFF8001; LHU -> 0x00008001.
//  LW addr 0x05 -> no mem_req ever, resp_valid next cycle, err=01; type=010 -> err=11.
//  No ack, TIMEOUT=15 -> mem_req high 15 cycles then low, resp_valid with err=10, data=0.
//  reset low mid-ACCESS -> mem_req=0 same cycle, no resp_valid; after release req_ready=1.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store initiator: one word-aligned memory access per accepted request, data returned sign/zero-extended.
// Latency: accept edge N, mem_req high after N, resp_valid one cycle after mem_ack is sampled; errors respond next cycle.
// Backpressure: req_ready only in IDLE; mem_* held stable until mem_ack or TIMEOUT cycles elapse.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [1:0]  resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] SZ_W  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;
    localparam logic [2:0] SZ_B  = 3'b110;
    localparam logic [2:0] SZ_BU = 3'b111;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_nxt;
    logic        we_q;
    logic [2:0]  type_q;
    logic [1:0]  off_q;
    logic [7:0]  cnt;
    logic        accept, type_ok, misal, timed_out;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt, load_data;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    // Request decode: lane enables and replicated store data
    always_comb begin
        type_ok   = req_type inside {SZ_W, SZ_H, SZ_HU, SZ_B, SZ_BU};
        misal     = ((req_type == SZ_W) && (req_addr[1:0] != 2'b00)) ||
                    (((req_type == SZ_H) || (req_type == SZ_HU)) && req_addr[0]);
        be_nxt    = 4'b1111;
        wdata_nxt = req_wdata;
        case (req_type)
            SZ_H, SZ_HU: begin
                be_nxt    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_nxt = {2{req_wdata[15:0]}};
            end
            SZ_B, SZ_BU: begin
                be_nxt    = 4'b0001 << req_addr[1:0];
                wdata_nxt = {4{req_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    // Load lane extraction from the returned word
    always_comb begin
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        byte_sel = mem_rdata[8*off_q +: 8];
        case (type_q)
            SZ_H:    load_data = {{16{half_sel[15]}}, half_sel};
            SZ_HU:   load_data = {16'h0000, half_sel};
            SZ_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            SZ_BU:   load_data = {24'h000000, byte_sel};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        accept     = req_valid && (state == IDLE);
        timed_out  = (cnt == CNT_LAST);
        state_nxt  = state;
        case (state)
            IDLE:    if (accept) state_nxt = (type_ok && !misal) ? ACCESS : RESP;
            ACCESS:  if (mem_ack || timed_out) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            type_q    <= 3'b000;
            off_q     <= 2'b00;
            cnt       <= 8'h00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'h0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            resp_data <= 32'h0;
            resp_err  <= 2'b00;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept) begin
                we_q   <= req_we;
                type_q <= req_type;
                off_q  <= req_addr[1:0];
                if (!type_ok) begin
                    resp_err  <= 2'b11;
                    resp_data <= 32'h0;
                end else if (misal) begin
                    resp_err  <= 2'b01;
                    resp_data <= 32'h0;
                end else begin
                    mem_req   <= 1'b1;
                    mem_we    <= req_we;
                    mem_be    <= be_nxt;
                    mem_addr  <= {req_addr[31:2], 2'b00};
                    mem_wdata <= wdata_nxt;
                    cnt       <= 8'h00;
                end
            end else if (state == ACCESS) begin
                // An ack in the final counted cycle still completes normally
                if (mem_ack) begin
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                    resp_err  <= 2'b00;
                    resp_data <= we_q ? 32'h0 : load_data;
                end else if (timed_out) begin
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                    resp_err  <= 2'b10;
                    resp_data <= 32'h0;
                end else begin
                    cnt <= cnt + 8'h01;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed spec cases, then random transactions against an arithmetic reference model.
module tb_lsu_ctrl;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_type = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [1:0]  resp_err;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int checks = 0;
    int failures = 0;

    lsu_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: sizes in bytes, lane offsets and extension as plain arithmetic
    task automatic model(input logic we, input logic [2:0] ty, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int ack_dly,
                         output logic [1:0] err, output logic [3:0] be, output logic [31:0] mwd,
                         output logic [31:0] data, output bit uses_mem);
        int     n, off;
        longint mask, v;
        n = (ty == 3'd0) ? 4 : (ty == 3'd4 || ty == 3'd5) ? 2 : (ty == 3'd6 || ty == 3'd7) ? 1 : 0;
        off = int'(addr % 4);
        be = 4'h0; mwd = 32'h0; data = 32'h0; uses_mem = 1'b0;
        if (n == 0) err = 2'b11;
        else if (addr % n != 0) err = 2'b01;
        else begin
            uses_mem = 1'b1;
            err = (ack_dly < 0 || ack_dly >= TO) ? 2'b10 : 2'b00;
            mask = (64'd1 << (8 * n)) - 1;
            be = 4'(((1 << n) - 1) << off);
            v = 0;
            for (int i = 0; i < 4; i += n) v = v | ((longint'(wd) & mask) << (8 * i));
            mwd = 32'(v);
            if (!we && err == 2'b00) begin
                v = (longint'(rd) >> (8 * off)) & mask;
                if ((ty == 3'd4 || ty == 3'd6) && v >= (mask + 1) / 2) v = v - (mask + 1);
                data = 32'(v);
            end
        end
    endtask

    // ack_dly: number of mem_req cycles before ack is given; negative means never
    task automatic txn(input logic we, input logic [2:0] ty, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input int ack_dly);
        logic [1:0]  e_err;
        logic [3:0]  e_be;
        logic [31:0] e_wd, e_data;
        bit          e_mem;
        int          k, e_k;
        model(we, ty, addr, wd, rd, ack_dly, e_err, e_be, e_wd, e_data, e_mem);
        e_k = !e_mem ? 0 : (e_err == 2'b10) ? TO : ack_dly + 1;
        @(negedge clk);
        chk("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_type = ty; req_addr = addr; req_wdata = wd;
        mem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        req_valid = 1'b0; mem_ack = 1'b0;
        k = 0;
        while (!resp_valid) begin
            chk("mem_req", 32'(mem_req), 32'd1);
            chk("ready_busy", 32'(req_ready), 32'd0);
            if (k == 0) begin
                chk("mem_we", 32'(mem_we), 32'(we));
                chk("mem_be", 32'(mem_be), 32'(e_be));
                chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
                if (we) chk("mem_wdata", mem_wdata, e_wd);
            end
            mem_ack   = (k == ack_dly);
            mem_rdata = (k == ack_dly) ? rd : $urandom;
            k++;
            if (k > TO + 3) begin
                chk("resp_timeout", 32'(resp_valid), 32'd1);
                break;
            end
            @(negedge clk);
            mem_ack = 1'b0;
        end
        chk("req_cycles", 32'(k), 32'(e_k));
        chk("resp_mem_req", 32'(mem_req), 32'd0);
        chk("resp_err", 32'(resp_err), 32'(e_err));
        chk("resp_data", resp_data, e_data);
        @(negedge clk);
        chk("resp_pulse", 32'(resp_valid), 32'd0);
        chk("resp_hold", resp_data, e_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);

        txn(1'b1, 3'b000, 32'h10, 32'hDEADBEEF, 32'h0, 2);
        txn(1'b1, 3'b110, 32'h13, 32'h000000A5, 32'h0, 0);
        txn(1'b0, 3'b110, 32'h13, 32'h0, 32'hA5000000, 0);
        chk("lb_value", resp_data, 32'hFFFFFFA5);
        txn(1'b0, 3'b111, 32'h13, 32'h0, 32'hA5000000, 1);
        chk("lbu_value", resp_data, 32'h000000A5);
        txn(1'b0, 3'b100, 32'h22, 32'h0, 32'h8001_1234, 0);
        chk("lh_value", resp_data, 32'hFFFF8001);
        txn(1'b0, 3'b101, 32'h22, 32'h0, 32'h8001_1234, 3);
        chk("lhu_value", resp_data, 32'h00008001);
        txn(1'b0, 3'b000, 32'h05, 32'h0, 32'h0, 0);
        txn(1'b0, 3'b010, 32'h08, 32'h0, 32'h0, 0);
        txn(1'b0, 3'b000, 32'h30, 32'h0, 32'h12345678, -1);
        txn(1'b0, 3'b000, 32'h34, 32'h0, 32'hCAFEF00D, TO - 1);

        // Reset asserted while the access is outstanding
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_type = 3'b000; req_addr = 32'h40; req_wdata = 32'h11;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_mem_req", 32'(mem_req), 32'd1);
        #2 reset = 1'b0;
        #1 chk("async_mem_req", 32'(mem_req), 32'd0);
        chk("async_resp", 32'(resp_valid), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_resp", 32'(resp_valid), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_resp", 32'(resp_valid), 32'd0);
        chk("post_rst_be", 32'(mem_be), 32'd0);

        for (int i = 0; i < 60; i++) begin
            int d;
            d = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
            txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
